// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit paths.
//   - rx_state_e : receiver FSM encoding
//   - OVERSAMPLE, MID_SAMPLE, DATA_BITS : framing constants
//   - calc_div() : clocks per oversample tick, rounded to nearest
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 7;
    localparam int unsigned DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Round-to-nearest divider from system clock to the oversample tick.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return (clk_freq + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst      : clock, synchronous active-high reset
//   push, wdata   : write request and data (ignored when full unless popping)
//   pop           : read request (ignored when empty)
//   rdata         : head entry, valid whenever empty is low
//   empty, full   : occupancy flags
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_pop;
    logic             do_push;

    // Extra pointer bit separates the full and empty cases.
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_q[AW-1:0]];

    // Storage and pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= wdata;
                wr_q                <= wr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive front end: 16x oversampled 8N1 receiver feeding a FWFT FIFO.
// Build option: define UART_RX_PARITY_EN for 8E1 frames with parity checking.
//   clk, rst   : clock, synchronous active-high reset
//   uart_rxd   : asynchronous serial input, idle high
//   rx_data    : byte at FIFO head
//   rx_valid   : FIFO not empty
//   rx_ready   : consumer pops head when rx_valid && rx_ready
//   frame_err  : one-cycle pulse, bad stop bit (or bad parity when enabled)
//   overrun    : one-cycle pulse, byte dropped on full FIFO
//   busy       : receiver not idle
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned DIV    = calc_div(CLK_FREQ, BAUD);
    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SAMP_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);

    rx_state_e              state_q;
    logic [1:0]             sync_q;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [SAMP_W-1:0]      samp_q, samp_d;
    logic [BIT_W-1:0]       bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   frame_err_q;
    logic                   overrun_q;
    logic                   rxd_s;
    logic                   tick;
    logic                   mid;
    logic                   parity_bad;
    logic                   push_c;
    logic                   pop_c;
    logic                   fifo_empty;
    logic                   fifo_full;

    assign rxd_s = sync_q[1];
    assign tick  = (state_q != ST_IDLE) && (div_q == DIV_W'(DIV - 1));
    assign mid   = tick && (samp_q == SAMP_W'(MID_SAMPLE));

`ifdef UART_RX_PARITY_EN
    logic perr_q;
    assign parity_bad = perr_q;
`else
    assign parity_bad = 1'b0;
`endif

    assign push_c = (state_q == ST_STOP) && mid && rxd_s && !parity_bad;
    assign pop_c  = rx_ready && !fifo_empty;

    // Divider and sample counter are held at zero in IDLE so bit phase starts at the edge.
    always_comb begin
        div_d  = div_q;
        samp_d = samp_q;
        if (state_q == ST_IDLE) begin
            div_d  = '0;
            samp_d = '0;
        end else if (tick) begin
            div_d  = '0;
            samp_d = (samp_q == SAMP_W'(OVERSAMPLE - 1)) ? '0 : samp_q + SAMP_W'(1);
        end else begin
            div_d  = div_q + DIV_W'(1);
        end
    end

    // Input synchronizer and oversampling counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            div_q  <= '0;
            samp_q <= '0;
        end else begin
            sync_q <= {sync_q[0], uart_rxd};
            div_q  <= div_d;
            samp_q <= samp_d;
        end
    end

    // Receiver FSM with registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q      <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= push_c && fifo_full && !pop_c;
            case (state_q)
                ST_IDLE: begin
                    if (!rxd_s) state_q <= ST_START;
                end
                ST_START: begin
                    if (mid) begin
                        if (rxd_s) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_DATA;
                            bit_q   <= '0;
`ifdef UART_RX_PARITY_EN
                            perr_q  <= 1'b0;
`endif
                        end
                    end
                end
                ST_DATA: begin
                    if (mid) begin
                        shift_q <= {rxd_s, shift_q[DATA_BITS-1:1]};
                        bit_q   <= bit_q + BIT_W'(1);
                        if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (mid) begin
                        perr_q  <= rxd_s ^ (^shift_q);
                        state_q <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (mid) begin
                        if (!rxd_s) begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_BREAK;
                        end else begin
                            frame_err_q <= parity_bad;
                            state_q     <= ST_IDLE;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rxd_s) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .wdata (shift_q),
        .pop   (rx_ready),
        .rdata (rx_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign rx_valid  = !fifo_empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo at default parameters (27 clocks per tick, 432 per bit).
module tb_uart_rx_fifo;

    localparam int unsigned BIT = 16 * 27;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FRAME = NBITS * BIT;
    // Stop mid-sample lands 8 ticks + (NBITS-1) bits after the start edge,
    // plus 2 synchronizer clocks and the IDLE->START clock.
    localparam int LAT = int'(BIT / 2 + (NBITS - 1) * BIT + 3);

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rxd  (uart_rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples on the falling edge, inputs change just after the rising edge.
    logic [7:0] obs_mem [256];
    int   obs_wr = 0;
    int   ferr_cnt = 0;
    int   ovr_cnt = 0;
    int   ovr_cyc = 0;
    int   rise_cnt = 0;
    int   rise_cyc = 0;
    logic busy_at_rise = 1'b0;
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        prev_valid <= rx_valid;
        if (!rst) begin
            if (rx_valid && rx_ready) begin
                obs_mem[obs_wr] <= rx_data;
                obs_wr          <= obs_wr + 1;
            end
            if (frame_err) ferr_cnt <= ferr_cnt + 1;
            if (overrun) begin
                ovr_cnt <= ovr_cnt + 1;
                ovr_cyc <= cyc;
            end
            if (rx_valid && !prev_valid) begin
                rise_cnt     <= rise_cnt + 1;
                rise_cyc     <= cyc;
                busy_at_rise <= busy;
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int         n_chk = 0;
    int         n_fail = 0;
    int         obs_rd = 0;
    int         last_start = 0;
    logic [7:0] exp_q [$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         ferr_inc;
        int         stored;
    } vec_t;
    vec_t vecs [3];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic par_bad);
        last_start = cyc;
        uart_rxd = 1'b0;
        step(BIT);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            step(BIT);
        end
`ifdef UART_RX_PARITY_EN
        uart_rxd = (^b) ^ par_bad;
        step(BIT);
`else
        if (par_bad) $display("note: parity not built, request ignored");
`endif
        uart_rxd = stop_bit;
        step(BIT);
    endtask

    // Pop every byte the scoreboard expects, in order, and flag extras.
    task automatic compare_sb(input string name);
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_rd < obs_wr) begin
                check(name, 32'(obs_mem[obs_rd]), 32'(e));
                obs_rd++;
            end else begin
                n_chk++;
                n_fail++;
                $display("FAIL %s: got no byte expected 0x%0h", name, e);
            end
        end
        check({name, " extra"}, obs_wr - obs_rd, 0);
    endtask

    task automatic drain(input string name);
        rx_ready = 1'b1;
        step(8);
        rx_ready = 1'b0;
        step(2);
        check({name, " rx_valid falls"}, 32'(rx_valid), 0);
        compare_sb(name);
    endtask

    int f0, r0, o0, t5;

    initial begin
        vecs[0] = '{8'h00, 1'b1, 0, 1};
        vecs[1] = '{8'hFF, 1'b1, 0, 1};
        vecs[2] = '{8'h5A, 1'b0, 1, 0};

        rst = 1'b1; uart_rxd = 1'b1; rx_ready = 1'b0;
        step(4);
        check("rst rx_data",   32'(rx_data),   0);
        check("rst rx_valid",  32'(rx_valid),  0);
        check("rst frame_err", 32'(frame_err), 0);
        check("rst overrun",   32'(overrun),   0);
        check("rst busy",      32'(busy),      0);
        rst = 1'b0;
        step(BIT);

        // 0x55: latency, data and status at the push
        f0 = ferr_cnt;
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b1, 1'b0);
        step(2);
        check("0x55 latency", rise_cyc - last_start, LAT);
        check("0x55 rx_valid", 32'(rx_valid), 1);
        check("0x55 rx_data", 32'(rx_data), 32'h55);
        check("0x55 busy at push", 32'(busy_at_rise), 0);
        check("0x55 frame_err", ferr_cnt - f0, 0);
        drain("0x55 pop");

        // Table of frames with the consumer always ready
        rx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            f0 = ferr_cnt; r0 = rise_cnt;
            if (vecs[i].stored != 0) exp_q.push_back(vecs[i].data);
            send_byte(vecs[i].data, vecs[i].stop, 1'b0);
            uart_rxd = 1'b1;
            step(BIT / 2);
            check($sformatf("vec%0d frame_err", i), ferr_cnt - f0, vecs[i].ferr_inc);
            check($sformatf("vec%0d pushes", i), rise_cnt - r0, vecs[i].stored);
        end
        rx_ready = 1'b0;
        step(2);
        compare_sb("table pop");

        // Start glitch of 5 ticks
        f0 = ferr_cnt; r0 = rise_cnt;
        uart_rxd = 1'b0;
        step(100);
        check("glitch busy in START", 32'(busy), 1);
        step(35);
        uart_rxd = 1'b1;
        step(95);
        check("glitch busy after mid", 32'(busy), 0);
        step(BIT);
        check("glitch frame_err", ferr_cnt - f0, 0);
        check("glitch pushes", rise_cnt - r0, 0);

        // Bad stop then long break: one error, then recovery
        f0 = ferr_cnt; r0 = rise_cnt;
        send_byte(8'hA3, 1'b0, 1'b0);
        step(3 * FRAME);
        check("break busy", 32'(busy), 1);
        uart_rxd = 1'b1;
        step(BIT);
        check("break frame_err count", ferr_cnt - f0, 1);
        check("break pushes", rise_cnt - r0, 0);
        check("break busy after", 32'(busy), 0);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1, 1'b0);
        step(4);
        drain("after break pop");

        // Back-to-back 0x01..0x05 into a 4-deep FIFO
        o0 = ovr_cnt;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b1, 1'b0);
        end
        t5 = last_start;
        step(2);
        check("overrun count", ovr_cnt - o0, 1);
        check("overrun timing", ovr_cyc - t5, LAT);
        check("overrun rx_data head", 32'(rx_data), 1);

        // Push into full FIFO with a pop in the same cycle
        exp_q.push_back(8'h06);
        fork
            send_byte(8'h06, 1'b1, 1'b0);
            begin
                step(LAT - 1);
                rx_ready = 1'b1;
                step(1);
                rx_ready = 1'b0;
            end
        join
        step(2);
        check("push+pop no overrun", ovr_cnt - o0, 1);
        drain("full push+pop order");

        // Reset during data bit 4 of 0xF0 (remaining line bits are high)
        fork
            send_byte(8'hF0, 1'b1, 1'b0);
            begin
                step(2300);
                check("pre-reset busy", 32'(busy), 1);
                rst = 1'b1;
                step(1);
                check("reset busy", 32'(busy), 0);
                check("reset rx_valid", 32'(rx_valid), 0);
                rst = 1'b0;
            end
        join
        step(BIT);
        r0 = rise_cnt;
        check("reset no push", 32'(rx_valid), 0);
        exp_q.push_back(8'h7E);
        send_byte(8'h7E, 1'b1, 1'b0);
        step(4);
        check("0x7E pushes", rise_cnt - r0, 1);
        drain("0x7E pop");

`ifdef UART_RX_PARITY_EN
        f0 = ferr_cnt; r0 = rise_cnt;
        send_byte(8'h7E, 1'b1, 1'b1);
        step(4);
        check("parity frame_err", ferr_cnt - f0, 1);
        check("parity no push", rise_cnt - r0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial receive front end of the SOPC UART. Consumes the asynchronous uart_rxd pin, the same line the system testbench drives at idle-high.
- Recovers 8N1 frames with 16x oversampling and buffers received bytes in a small first-word-fall-through FIFO.
- Presents bytes to the bus-side UART register block over a valid/ready handshake, with framing-error and overrun pulses for the status register.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- FIFO_DEPTH, 4, receive buffer entries; must be a power of 2 and at least 2.
- DIV (localparam), (CLK_FREQ + BAUD*8)/(BAUD*16), clocks per oversample tick; 27 at the defaults.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- uart_rxd  in  1  asynchronous serial input, idle high.
- rx_data  out  8  byte at the FIFO head.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer pops the head when rx_valid and rx_ready are both high.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte dropped because the FIFO was full.
- busy  out  1  high in any receiver state other than IDLE.

Behaviour:
- Reset, applied on a clk edge with rst=1:
  - 2-flop synchronizer set to 1.
  - Tick divider, sample counter and bit counter cleared; FSM to IDLE.
  - FIFO emptied.
  - All outputs 0.
  - Reset mid-frame abandons the frame; nothing is pushed.
- Tick generator:
  - Divider counts 0..DIV-1 and emits tick at DIV-1.
  - It restarts at 0 on the IDLE->START transition so bit phase aligns to the start edge.
- Sample counter counts ticks 0..15 within each bit. The bit is sampled at sample count 7, i.e. mid-bit.
- FSM:
  - IDLE: synchronized rxd=0 -> START.
  - START: at mid-bit, rxd=1 -> IDLE (glitch rejected, no error). rxd=0 -> DATA, bit counter cleared.
  - DATA: at each mid-bit, shift rxd into the MSB of the shift register (LSB first on the line). After the 8th bit -> STOP.
  - STOP: at mid-bit, rxd=1 -> push the byte and go to IDLE. Leaving at mid-stop lets back-to-back frames resync on the next start edge. rxd=0 -> frame_err pulse, byte discarded, -> BREAK.
  - BREAK: wait until synchronized rxd=1, then -> IDLE. A held-low line therefore raises exactly one frame_err.
- FIFO (sub-module):
  - Pointers are log2(FIFO_DEPTH)+1 bits wide: empty when equal, full when the MSBs differ and the rest are equal.
  - rx_data is the registered head and is valid in the same cycle rx_valid is high.
  - Push latency: rx_valid rises on the clk edge after the stop mid-sample.
  - Push when full with no pop: byte dropped, overrun pulses, FIFO contents unchanged.
  - Push when full with a pop in the same cycle: both are performed, no overrun.
  - Push and pop when empty: the byte is stored and rx_valid rises next cycle; the pop is ignored because rx_valid was low.
  - Pop when empty: ignored.

Optional Feature:
- UART_RX_PARITY_EN defined:
  - Frame becomes 8E1; an extra PARITY state sits between DATA and STOP.
  - Mismatch between the received bit and the XOR of the data bits sets a pending flag.
  - At the stop bit a pending mismatch gives a frame_err pulse and the byte is discarded. A pending mismatch with stop=0 still gives one pulse and goes to BREAK.
- Undefined: no PARITY state, 8N1 only; all logic for the feature is absent.

Decomposition:
- Package uart_pkg:
  - FSM state encoding: IDLE, START, DATA, PARITY, STOP, BREAK.
  - OVERSAMPLE=16, MID_SAMPLE=7, DATA_BITS=8.
  - Divider-rounding function.
- One sub-module, uart_sync_fifo:
  - Parameters WIDTH and DEPTH.
  - Ports: push, wdata, pop, rdata, empty, full.
  - Reused later by the transmit path.

Test Plan:
- 0x55 sent at the defaults (DIV=27) -> rx_valid rises about 9.5 bit times (≈4104 clocks) after the start edge; rx_data=0x55; frame_err=0; busy low after mid-stop.
- uart_rxd low for 5 ticks (135 clocks) then high -> no push, no frame_err; FSM back in IDLE by the START mid-sample.
- 0xA3 sent with stop bit 0, line then held low for 3 frame times -> exactly one frame_err pulse, rx_valid stays 0; the next valid 0x3C after the line returns high is received correctly.
- Bytes 0x01..0x05 sent back-to-back (no idle gap) with rx_ready=0 -> overrun pulses once, at the 5th stop mid-sample. With rx_ready then held 1, pops return 0x01,0x02,0x03,0x04 and rx_valid falls.
- FIFO full with rx_ready=1 in the same cycle as a push -> no overrun; the order of all entries is preserved.
- rst=1 asserted during DATA bit 4 of a frame -> next cycle busy=0 and rx_valid=0. A following 0x7E frame is received intact. Under UART_RX_PARITY_EN, a bad parity bit on 0x7E gives frame_err and no push.
